// File: rtl/key_sw_ctrl_pkg.sv
// Shared constants and status-register helpers for the KEY/SW input controller.
package key_sw_ctrl_pkg;

    localparam int          DEBOUNCE_DEF = 500000;
    localparam logic [31:0] ADDRKEY_DEF  = 32'hFFFFF080;
    localparam logic [31:0] ADDRSW_DEF   = 32'hFFFFF090;

    localparam int CTRL_RDY = 0;
    localparam int CTRL_OVR = 2;
    localparam int CTRL_IE  = 4;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic rdy;
    } status_t;

    // Event beats both a data read and a CTRL write; OVR only flags an unread, unconsumed RDY.
    function automatic status_t status_next(
        input status_t     cur,
        input logic        evt,
        input logic        data_rd,
        input logic        ctrl_wr,
        input logic [31:0] wd
    );
        status_t nxt;
        nxt = cur;
        if (ctrl_wr) begin
            nxt.ie = wd[CTRL_IE];
        end else begin
            nxt.ie = cur.ie;
        end
        if (evt) begin
            nxt.rdy = 1'b1;
        end else if ((ctrl_wr && !wd[CTRL_RDY]) || data_rd) begin
            nxt.rdy = 1'b0;
        end else begin
            nxt.rdy = cur.rdy;
        end
        if (evt && cur.rdy && !data_rd) begin
            nxt.ovr = 1'b1;
        end else if (ctrl_wr && !wd[CTRL_OVR]) begin
            nxt.ovr = 1'b0;
        end else begin
            nxt.ovr = cur.ovr;
        end
        return nxt;
    endfunction

    function automatic logic [31:0] ctrl_word(input status_t s);
        return {27'd0, s.ie, 1'b0, s.ovr, 1'b0, s.rdy};
    endfunction

endpackage

// File: rtl/key_sw_ctrl_io_debounce.sv
// Two-flop synchroniser plus a group debouncer: a change must hold for CYCLES cycles before it is accepted.
module io_debounce
    import key_sw_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_stable,
    output logic             o_event
);

    localparam int            CW   = $clog2(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_cand;
    logic [CW-1:0]    r_cnt;
    logic [0:0]       r_state;
    logic             w_event;

    // The acceptance pulse is decoded from state so the status flops latch it on the same edge as stable.
    assign w_event  = (r_state == ST_COUNT) && (r_sync != r_stable) &&
                      (r_sync == r_cand) && (r_cnt == LAST);
    assign o_stable = r_stable;
    assign o_event  = w_event;

    // Synchroniser and debounce state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta   <= '0;
            r_sync   <= '0;
            r_stable <= '0;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_state  <= ST_IDLE;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
            case (r_state)
                ST_IDLE: begin
                    if (r_sync != r_stable) begin
                        r_cand  <= r_sync;
                        r_cnt   <= '0;
                        r_state <= ST_COUNT;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_COUNT: begin
                    if (r_sync == r_stable) begin
                        r_state <= ST_IDLE;
                    end else if (r_sync != r_cand) begin
                        r_cand <= r_sync;
                        r_cnt  <= '0;
                    end else if (r_cnt == LAST) begin
                        r_stable <= r_cand;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_sw_ctrl.sv
// Memory-mapped KEY/SW controller: debounced inputs, Ready/Overrun status, interrupt enable, read mux.
module key_sw_ctrl
    import key_sw_ctrl_pkg::*;
#(
    parameter int               DBITS           = 32,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter logic [DBITS-1:0] ADDRKEY         = DBITS'(ADDRKEY_DEF),
    parameter logic [DBITS-1:0] ADDRSW          = DBITS'(ADDRSW_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wrdata,
    input  logic             we,
    input  logic             re,
    output logic [DBITS-1:0] rdata,
    output logic             hit,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic             irq
);

    localparam logic [DBITS-1:0] ADDR_KDATA = ADDRKEY;
    localparam logic [DBITS-1:0] ADDR_KCTRL = ADDRKEY + DBITS'(4);
    localparam logic [DBITS-1:0] ADDR_SDATA = ADDRSW;
    localparam logic [DBITS-1:0] ADDR_SCTRL = ADDRSW + DBITS'(4);

    logic [3:0] w_key_db;
    logic [9:0] w_sw_db;
    logic       w_key_evt;
    logic       w_sw_evt;
    logic       w_hit_kdata;
    logic       w_hit_kctrl;
    logic       w_hit_sdata;
    logic       w_hit_sctrl;
    status_t    r_kst;
    status_t    r_sst;
    logic       r_irq;

    // Keys are active-low at the pins; the debouncer works on the pressed mask.
    io_debounce #(.WIDTH(4), .CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clk      (clk),
        .reset    (reset),
        .i_din    (~KEY),
        .o_stable (w_key_db),
        .o_event  (w_key_evt)
    );

    io_debounce #(.WIDTH(10), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk      (clk),
        .reset    (reset),
        .i_din    (SW),
        .o_stable (w_sw_db),
        .o_event  (w_sw_evt)
    );

    assign w_hit_kdata = (addr == ADDR_KDATA);
    assign w_hit_kctrl = (addr == ADDR_KCTRL);
    assign w_hit_sdata = (addr == ADDR_SDATA);
    assign w_hit_sctrl = (addr == ADDR_SCTRL);
    assign hit         = w_hit_kdata | w_hit_kctrl | w_hit_sdata | w_hit_sctrl;
    assign irq         = r_irq;

    // Combinational read mux; misses return zero.
    always_comb begin
        rdata = '0;
        if (w_hit_kdata) begin
            rdata = DBITS'({28'd0, w_key_db});
        end else if (w_hit_kctrl) begin
            rdata = DBITS'(ctrl_word(r_kst));
        end else if (w_hit_sdata) begin
            rdata = DBITS'({22'd0, w_sw_db});
        end else if (w_hit_sctrl) begin
            rdata = DBITS'(ctrl_word(r_sst));
        end else begin
            rdata = '0;
        end
    end

    // Status flops per group and the registered interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kst <= '0;
            r_sst <= '0;
            r_irq <= 1'b0;
        end else begin
            r_kst <= status_next(r_kst, w_key_evt, re && w_hit_kdata,
                                 we && w_hit_kctrl, 32'(wrdata));
            r_sst <= status_next(r_sst, w_sw_evt, re && w_hit_sdata,
                                 we && w_hit_sctrl, 32'(wrdata));
            r_irq <= (r_kst.rdy & r_kst.ie) | (r_sst.rdy & r_sst.ie);
        end
    end

endmodule

// File: tb/tb_key_sw_ctrl.sv
// Directed bench for key_sw_ctrl with a 4-cycle debounce interval.
module tb_key_sw_ctrl;

    localparam logic [31:0] KDATA = 32'hFFFFF080;
    localparam logic [31:0] KCTRL = 32'hFFFFF084;
    localparam logic [31:0] SDATA = 32'hFFFFF090;
    localparam logic [31:0] SCTRL = 32'hFFFFF094;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        hit;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic        irq;

    int tests = 0;
    int fails = 0;

    key_sw_ctrl #(.DBITS(32), .DEBOUNCE_CYCLES(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wrdata (wrdata),
        .we     (we),
        .re     (re),
        .rdata  (rdata),
        .hit    (hit),
        .KEY    (KEY),
        .SW     (SW),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr   = a;
        wrdata = d;
        we     = 1'b1;
        cyc(1);
        we     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = KDATA; wrdata = '0; we = 1'b0; re = 1'b0;
        KEY = 4'hF; SW = 10'h000;
        cyc(3);
        reset = 1'b0;
        rd("rst_kdata", KDATA, 32'h0);
        chk("rst_hit", {31'd0, hit}, 32'h1);
        rd("rst_kctrl", KCTRL, 32'h0);
        rd("rst_sctrl", SCTRL, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        rd("miss_rdata", 32'hFFFFF088, 32'h0);
        chk("miss_hit", {31'd0, hit}, 32'h0);
        wr(KDATA, 32'hFFFF_FFFF);
        rd("kdata_wr_ignored", KDATA, 32'h0);

        // Key 0 pressed: visible exactly 7 cycles after the pin change.
        KEY = 4'b1110;
        cyc(6);
        rd("k_lat6_data", KDATA, 32'h0);
        rd("k_lat6_ctrl", KCTRL, 32'h0);
        cyc(1);
        rd("k_lat7_data", KDATA, 32'h1);
        rd("k_lat7_ctrl", KCTRL, 32'h1);
        cyc(3);
        chk("k_irq_ie0", {31'd0, irq}, 32'h0);
        KEY = 4'hF;
        cyc(8);
        rd("k_ovr_data", KDATA, 32'h0);
        rd("k_ovr_ctrl", KCTRL, 32'h5);
        wr(KCTRL, 32'h0);
        rd("k_ctrl_clear", KCTRL, 32'h0);

        // Glitching switch never produces an event.
        for (int i = 0; i < 10; i++) begin
            SW[3] = 1'b1;
            cyc(1);
            SW[3] = 1'b0;
            cyc(1);
        end
        cyc(10);
        rd("glitch_sdata", SDATA, 32'h0);
        rd("glitch_sctrl", SCTRL, 32'h0);

        // Interrupt path on the switch group.
        wr(SCTRL, 32'h10);
        rd("s_ie_set", SCTRL, 32'h10);
        SW = 10'h2A5;
        cyc(6);
        rd("s_lat6_ctrl", SCTRL, 32'h10);
        cyc(1);
        rd("s_data", SDATA, 32'h2A5);
        rd("s_ctrl_rdy", SCTRL, 32'h11);
        chk("s_irq_before", {31'd0, irq}, 32'h0);
        cyc(1);
        chk("s_irq_after", {31'd0, irq}, 32'h1);
        addr = SDATA;
        re   = 1'b1;
        cyc(1);
        re   = 1'b0;
        rd("s_rd_clears", SCTRL, 32'h10);
        cyc(1);
        chk("s_irq_cleared", {31'd0, irq}, 32'h0);

        // Data read coinciding with the event pulse: event wins, no overrun.
        KEY = 4'b0101;
        cyc(6);
        rd("k_pre_evt", KDATA, 32'h0);
        re = 1'b1;
        cyc(1);
        re = 1'b0;
        rd("k_rd_evt_ctrl", KCTRL, 32'h1);
        rd("k_rd_evt_data", KDATA, 32'hA);

        // Reset mid-count on switches aborts the count.
        SW = 10'h0F0;
        cyc(5);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        rd("mid_rst_sdata", SDATA, 32'h0);
        rd("mid_rst_sctrl", SCTRL, 32'h0);
        rd("mid_rst_kctrl", KCTRL, 32'h0);
        cyc(6);
        rd("post_rst_6_sdata", SDATA, 32'h0);
        rd("post_rst_6_sctrl", SCTRL, 32'h0);
        cyc(1);
        rd("post_rst_7_sdata", SDATA, 32'h0F0);
        rd("post_rst_7_sctrl", SCTRL, 32'h1);
        rd("post_rst_7_kdata", KDATA, 32'hA);
        rd("post_rst_7_kctrl", KCTRL, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
